// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: I/D requester handshakes and the shared memory port.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_cmd;
  logic [31:0] d_addr;
  logic [3:0]  d_mask;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic        mem_enable;
  logic        mem_cmd;
  logic [31:0] mem_wdata;
  logic [31:0] mem_load_data;
  logic        mem_valid;

  logic        busy;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rvalid, i_rdata,
    input  d_req, d_cmd, d_addr, d_mask, d_wdata,
    output d_ready, d_rvalid, d_rdata,
    output mem_addr, mem_mask, mem_enable,
    output mem_cmd, mem_wdata,
    input  mem_load_data, mem_valid,
    output busy
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rvalid, i_rdata,
    output d_req, d_cmd, d_addr, d_mask, d_wdata,
    input  d_ready, d_rvalid, d_rdata,
    input  mem_addr, mem_mask, mem_enable,
    input  mem_cmd, mem_wdata,
    output mem_load_data, mem_valid,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (I) and load/store (D).
// Ports: clk, reset (async, active-low), bus (mem_arbiter_if.slave).
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic CMD_READ = 1'b0;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;

  logic          grant_i;
  logic          grant_d;
  logic          pick_d;

  logic          win_d_q;
  logic          cmd_q;
  logic [31:0]   addr_q;
  logic [3:0]    mask_q;
  logic [31:0]   wdata_q;

  logic          i_rvalid_q;
  logic          d_rvalid_q;
  logic [31:0]   i_rdata_q;
  logic [31:0]   d_rdata_q;
  logic [31:0]   rsp_data;

  logic          acc;
  logic [31:0]   m_addr;
  logic [3:0]    m_mask;
  logic          m_cmd;
  logic [31:0]   m_wdata;

  // D wins unless I is waiting and D has used up its streak.
  assign pick_d = bus.d_req &&
                  (!bus.i_req || streak_q != STREAK_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    acc      = 1'b0;
    m_addr   = '0;
    m_mask   = '0;
    m_cmd    = 1'b0;
    m_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        // readys stay low while reset is held
        unique case (1'b1)
          reset && pick_d:
            grant_d = 1'b1;
          reset && !pick_d && bus.i_req:
            grant_i = 1'b1;
          default: ;
        endcase
        if (grant_d) begin
          state_d = ACCESS;
          if (!bus.i_req)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + SW'(1);
        end else if (grant_i) begin
          state_d  = ACCESS;
          streak_d = '0;
        end
      end
      ACCESS: begin
        acc     = 1'b1;
        m_addr  = addr_q;
        m_mask  = mask_q;
        m_cmd   = cmd_q;
        m_wdata = wdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured only on the acceptance edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_d_q <= 1'b0;
      cmd_q   <= CMD_READ;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
    end else if (grant_d) begin
      win_d_q <= 1'b1;
      cmd_q   <= bus.d_cmd;
      addr_q  <= bus.d_addr;
      mask_q  <= bus.d_mask;
      wdata_q <= bus.d_wdata;
    end else if (grant_i) begin
      win_d_q <= 1'b0;
      cmd_q   <= CMD_READ;
      addr_q  <= bus.i_addr;
      mask_q  <= 4'b1111;
      wdata_q <= '0;
    end
  end

  assign rsp_data = (cmd_q == CMD_READ && bus.mem_valid) ?
                    bus.mem_load_data : 32'h0;

  // rdata of a port holds until that port's next response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      if (state_q == ACCESS) begin
        if (win_d_q) begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= rsp_data;
        end else begin
          i_rvalid_q <= 1'b1;
          i_rdata_q  <= rsp_data;
        end
      end
    end
  end

  assign bus.i_ready    = grant_i;
  assign bus.d_ready    = grant_d;
  assign bus.i_rvalid   = i_rvalid_q;
  assign bus.d_rvalid   = d_rvalid_q;
  assign bus.i_rdata    = i_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.mem_enable = acc;
  assign bus.mem_addr   = m_addr;
  assign bus.mem_mask   = m_mask;
  assign bus.mem_cmd    = m_cmd;
  assign bus.mem_wdata  = m_wdata;
  assign bus.busy       = acc;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic against a
// transaction-level model of the arbiter and memory.
module tb_mem_arbiter;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'hAAAAAAAA;
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h cycle %0d",
               name, act, want, cyc);
    end
  endtask

  // memory: unwritten words read as init_word
  logic [31:0]  mem [256];
  logic [255:0] wr = '0;
  logic [7:0]   widx;
  logic [31:0]  wcur;

  assign widx = bus.mem_addr[9:2];
  assign wcur = wr[widx] ? mem[widx] : init_word(int'(widx));
  assign bus.mem_load_data = bus.mem_enable ? wcur : 32'h0;
  assign bus.mem_valid = bus.mem_enable;

  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_cmd) begin
      mem[widx] <= merge(wcur, bus.mem_wdata, bus.mem_mask);
      wr[widx]  <= 1'b1;
    end
  end

  // reference model, one step per cycle at the falling edge
  logic [31:0] ref_mem [256];
  bit          m_acc;
  bit          m_win_d;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_mask;
  logic        m_cmd;
  int          m_streak;
  bit          rsp_i;
  bit          rsp_d;
  logic [31:0] e_ir;
  logic [31:0] e_dr;

  initial begin
    logic [31:0] data;
    logic [7:0]  ix;
    bit          pd;
    bit          pi;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    m_acc = 0; rsp_i = 0; rsp_d = 0;
    e_ir = 0; e_dr = 0; m_streak = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_enable", bus.mem_enable, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_i_ready", bus.i_ready, 0);
        check("rst_d_ready", bus.d_ready, 0);
        check("rst_i_rvalid", bus.i_rvalid, 0);
        check("rst_d_rvalid", bus.d_rvalid, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_busy", bus.busy, 0);
        m_acc = 0; rsp_i = 0; rsp_d = 0;
        e_ir = 0; e_dr = 0; m_streak = 0;
      end else begin
        check("i_rvalid", bus.i_rvalid, rsp_i);
        check("d_rvalid", bus.d_rvalid, rsp_d);
        check("i_rdata", bus.i_rdata, e_ir);
        check("d_rdata", bus.d_rdata, e_dr);
        rsp_i = 0;
        rsp_d = 0;
        if (m_acc) begin
          check("acc_enable", bus.mem_enable, 1);
          check("acc_addr", bus.mem_addr, m_addr);
          check("acc_mask", bus.mem_mask, m_mask);
          check("acc_cmd", bus.mem_cmd, m_cmd);
          check("acc_wdata", bus.mem_wdata, m_wdata);
          check("acc_busy", bus.busy, 1);
          check("acc_i_ready", bus.i_ready, 0);
          check("acc_d_ready", bus.d_ready, 0);
          ix = m_addr[9:2];
          if (m_cmd == 1'b0) begin
            data = ref_mem[ix];
          end else begin
            data = 0;
            ref_mem[ix] = merge(ref_mem[ix], m_wdata, m_mask);
          end
          if (m_win_d) begin
            rsp_d = 1; e_dr = data;
          end else begin
            rsp_i = 1; e_ir = data;
          end
          m_acc = 0;
        end else begin
          check("idle_enable", bus.mem_enable, 0);
          check("idle_addr", bus.mem_addr, 0);
          check("idle_mask", bus.mem_mask, 0);
          check("idle_cmd", bus.mem_cmd, 0);
          check("idle_wdata", bus.mem_wdata, 0);
          check("idle_busy", bus.busy, 0);
          pd = bus.d_req && (!bus.i_req || m_streak < MAXS);
          pi = !pd && bus.i_req;
          check("d_ready", bus.d_ready, pd);
          check("i_ready", bus.i_ready, pi);
          if (pd) begin
            m_acc = 1; m_win_d = 1;
            m_addr = bus.d_addr; m_cmd = bus.d_cmd;
            m_mask = bus.d_mask; m_wdata = bus.d_wdata;
            if (!bus.i_req) m_streak = 0;
            else if (m_streak < MAXS) m_streak++;
          end else if (pi) begin
            m_acc = 1; m_win_d = 0;
            m_addr = bus.i_addr; m_cmd = 0;
            m_mask = 4'hF; m_wdata = 0;
            m_streak = 0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one request; returns data, accept-to-rvalid latency, access addr
  task automatic do_req(input bit is_d, input logic cmd,
                        input logic [31:0] addr,
                        input logic [3:0] mask,
                        input logic [31:0] wd,
                        output logic [31:0] data,
                        output int lat,
                        output logic [31:0] acc_addr);
    int ta;
    int tr;
    ta = -1; tr = -1; data = 0; lat = -1;
    acc_addr = 32'hFFFFFFFF;
    tick();
    if (is_d) begin
      bus.d_req = 1; bus.d_cmd = cmd; bus.d_addr = addr;
      bus.d_mask = mask; bus.d_wdata = wd;
    end else begin
      bus.i_req = 1; bus.i_addr = addr;
    end
    for (int k = 0; k < 20 && ta < 0; k++) begin
      @(negedge clk);
      if (is_d ? bus.d_ready : bus.i_ready) ta = cyc;
    end
    tick();
    bus.d_req = 0;
    bus.i_req = 0;
    if (ta < 0) begin
      check("ready_timeout", 0, 1);
      return;
    end
    @(negedge clk);
    if (bus.mem_enable) acc_addr = bus.mem_addr;
    for (int k = 0; k < 6 && tr < 0; k++) begin
      if (is_d ? bus.d_rvalid : bus.i_rvalid) begin
        tr = cyc;
        data = is_d ? bus.d_rdata : bus.i_rdata;
      end else begin
        @(negedge clk);
      end
    end
    if (tr >= 0) lat = tr - ta;
  endtask

  initial begin
    logic [31:0] data;
    logic [31:0] aa;
    logic [31:0] dd;
    logic [31:0] id;
    int          lat;
    int          td;
    int          ti;
    int          both;
    int          cnt;
    int          last;
    int          gap_bad;
    bit          dr;
    bit          ir;
    bit          i_acc;
    bit          d_acc;
    string       seq;

    reset = 0;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_cmd = 0; bus.d_addr = 0;
    bus.d_mask = 0; bus.d_wdata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;

    // I alone
    do_req(0, 0, 32'h10, 4'hF, 0, data, lat, aa);
    check("i_alone_lat", lat, 2);
    check("i_alone_addr", aa, 32'h10);
    check("i_alone_rdata", data, 32'hDEADBEEF);
    @(negedge clk);
    check("i_alone_pulse", bus.i_rvalid, 0);

    // D partial write then read back
    do_req(1, 1, 32'h20, 4'b0011, 32'h12345678, data, lat, aa);
    check("d_wr_lat", lat, 2);
    check("d_wr_rdata", data, 0);
    @(negedge clk);
    check("d_wr_pulse", bus.d_rvalid, 0);
    do_req(1, 0, 32'h20, 4'hF, 0, data, lat, aa);
    check("d_rd_back", data, 32'hAAAA5678);

    // back-to-back: D read 0x0 and I read 0x4 together
    tick();
    bus.d_req = 1; bus.d_cmd = 0; bus.d_addr = 0;
    bus.d_mask = 4'hF; bus.i_req = 1; bus.i_addr = 32'h4;
    td = -1; ti = -1; both = 0; dd = 0; id = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.d_rvalid && bus.i_rvalid) both++;
      if (bus.d_rvalid) begin td = cyc; dd = bus.d_rdata; end
      if (bus.i_rvalid) begin ti = cyc; id = bus.i_rdata; end
      dr = bus.d_ready;
      ir = bus.i_ready;
      tick();
      if (dr) bus.d_req = 0;
      if (ir) bus.i_req = 0;
    end
    check("b2b_d_first", (td >= 0 && ti >= 0) ? ti - td : -1, 2);
    check("b2b_both", both, 0);
    check("b2b_d_data", dd, init_word(0));
    check("b2b_i_data", id, init_word(1));

    // contention with both requests held
    bus.d_req = 1; bus.d_cmd = 0; bus.d_addr = 32'h44;
    bus.d_mask = 4'hF; bus.i_req = 1; bus.i_addr = 32'h40;
    seq = ""; last = -1; gap_bad = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (bus.d_ready || bus.i_ready) begin
        seq = {seq, bus.d_ready ? "D" : "I"};
        if (last >= 0 && cyc - last != 2) gap_bad++;
        last = cyc;
      end
      tick();
    end
    bus.d_req = 0;
    bus.i_req = 0;
    total++;
    if (seq.len() < 10 || seq.substr(0, 9) != "DDDDIDDDDI") begin
      bad++;
      $display("FAIL contention_seq: got %s want DDDDIDDDDI", seq);
    end
    check("contention_gap", gap_bad, 0);
    repeat (4) tick();

    // withdrawn I request during a D access
    tick();
    bus.d_req = 1; bus.d_cmd = 0; bus.d_addr = 32'h48;
    cnt = 0;
    for (int k = 0; k < 20 && !bus.d_ready; k++) @(negedge clk);
    tick();
    bus.d_req = 0;
    bus.i_req = 1; bus.i_addr = 32'h50;
    @(negedge clk);
    if (bus.i_ready) cnt++;
    tick();
    bus.i_req = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.i_ready || bus.i_rvalid) cnt++;
    end
    check("withdrawn_i", cnt, 0);

    // reset during the access cycle of a D read
    tick();
    bus.d_req = 1; bus.d_cmd = 0; bus.d_addr = 32'h4C;
    for (int k = 0; k < 20 && !bus.d_ready; k++) @(negedge clk);
    tick();
    bus.d_req = 0;
    check("pre_rst_enable", bus.mem_enable, 1);
    reset = 0;
    #1;
    check("mid_rst_enable", bus.mem_enable, 0);
    check("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    tick();
    reset = 1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.d_rvalid) cnt++;
    end
    check("mid_rst_no_rvalid", cnt, 0);
    do_req(1, 0, 32'h4C, 4'hF, 0, data, lat, aa);
    check("reissue_lat", lat, 2);
    check("reissue_data", data, init_word(19));

    // random traffic
    i_acc = 0; d_acc = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      i_acc = bus.i_ready;
      d_acc = bus.d_ready;
      tick();
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if (bus.i_req && !i_acc) begin
        if ($urandom_range(0, 9) == 0) bus.i_req = 0;
      end else begin
        bus.i_req = 1'($urandom_range(0, 1));
        bus.i_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (bus.d_req && !d_acc) begin
        if ($urandom_range(0, 9) == 0) bus.d_req = 0;
      end else begin
        bus.d_req = 1'($urandom_range(0, 1));
        bus.d_cmd = 1'($urandom_range(0, 1));
        bus.d_addr = 32'($urandom_range(0, 255)) << 2;
        bus.d_mask = 4'($urandom_range(0, 15));
        bus.d_wdata = $urandom;
      end
    end
    reset = 1;
    bus.i_req = 0;
    bus.d_req = 0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
